// File: rtl/apply_move.sv
// Othello move applier: places a disc, then walks each flip direction.
// Optional flip counter: define APPLY_MOVE_FLIP_COUNT_EN.
module apply_move (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic [7:0] valid_dirs,
  input  logic       player,
  input  logic [1:0] q,
  output logic [5:0] address,
  output logic [1:0] data,
  output logic       wren,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] flip_count
);

  typedef enum logic [2:0] {
    IDLE, PLACE, DIR_SEL, RD_ADDR,
    RD_WAIT, EVAL, WR, DONE
  } state_t;

  state_t     state, state_n;
  logic [2:0] ox, oy;
  logic [2:0] cx, cy;
  logic [2:0] dir;
  logic       pl;
  logic [7:0] pend;
  logic       err;

  logic [2:0] sel;
  logic       has;
  logic [3:0] nbx, nby, stx, sty;
  logic       nb_off, st_off;

  // 4-bit two's complement column step for a direction
  function automatic logic [3:0] dlt_x(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dlt_x = 4'b0001;
      3'd3, 3'd4, 3'd5: dlt_x = 4'b1111;
      default:          dlt_x = 4'b0000;
    endcase
  endfunction

  // 4-bit two's complement row step for a direction
  function automatic logic [3:0] dlt_y(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dlt_y = 4'b1111;
      3'd5, 3'd6, 3'd7: dlt_y = 4'b0001;
      default:          dlt_y = 4'b0000;
    endcase
  endfunction

  // lowest pending direction; descending scan lets the lowest win
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pend[i]) sel = i[2:0];
    has = |pend;
  end

  // neighbour of the origin and next cursor step; bit 3 flags off-board
  always_comb begin
    nbx    = {1'b0, ox} + dlt_x(sel);
    nby    = {1'b0, oy} + dlt_y(sel);
    stx    = {1'b0, cx} + dlt_x(dir);
    sty    = {1'b0, cy} + dlt_y(dir);
    nb_off = nbx[3] | nby[3];
    st_off = stx[3] | sty[3];
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = PLACE;
      PLACE:   state_n = DIR_SEL;
      DIR_SEL: begin
        if (!has)        state_n = DONE;
        else if (nb_off) state_n = DIR_SEL;
        else             state_n = RD_ADDR;
      end
      RD_ADDR: state_n = RD_WAIT;
      RD_WAIT: state_n = EVAL;
      EVAL: begin
        if (q == {1'b1, ~pl}) state_n = WR;
        else                  state_n = DIR_SEL;
      end
      WR: begin
        if (st_off) state_n = DIR_SEL;
        else        state_n = RD_ADDR;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // latched move, pending mask, cursor and error flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox   <= '0;
      oy   <= '0;
      pl   <= 1'b0;
      pend <= '0;
      cx   <= '0;
      cy   <= '0;
      dir  <= '0;
      err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          ox   <= x;
          oy   <= y;
          pl   <= player;
          pend <= valid_dirs;
          err  <= 1'b0;
        end
        DIR_SEL: if (has) begin
          pend[sel] <= 1'b0;
          if (nb_off) begin
            err <= 1'b1;
          end else begin
            cx  <= nbx[2:0];
            cy  <= nby[2:0];
            dir <= sel;
          end
        end
        EVAL: if (!q[1]) err <= 1'b1;
        WR: begin
          if (st_off) begin
            err <= 1'b1;
          end else begin
            cx <= stx[2:0];
            cy <= sty[2:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef APPLY_MOVE_FLIP_COUNT_EN
  logic [5:0] fcnt;

  // saturating count of flipped cells
  always_ff @(posedge clk) begin
    if (!resetn)
      fcnt <= '0;
    else if (state == IDLE && start)
      fcnt <= '0;
    else if (state == WR && fcnt != 6'h3f)
      fcnt <= fcnt + 6'd1;
  end

  assign flip_count = fcnt;
`else
  assign flip_count = 6'd0;
`endif

  // RAM controls decoded from state and registers only
  always_comb begin
    wren    = 1'b0;
    data    = 2'b00;
    address = 6'd0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      PLACE: begin
        wren    = 1'b1;
        address = {oy, ox};
        data    = {1'b1, pl};
      end
      RD_ADDR, RD_WAIT, EVAL:
        address = {cy, cx};
      WR: begin
        wren    = 1'b1;
        address = {cy, cx};
        data    = {1'b1, pl};
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign error = err;

endmodule
